// File: rtl/stream_demux_pkg.sv
// Shared defaults and types for the round-robin / addressed stream demultiplexer.
package stream_demux_pkg;
  localparam int N_OUT_DEF = 4;
  localparam int W_DEF     = 8;
  typedef logic [$clog2(N_OUT_DEF)-1:0] dest_t;
endpackage

// File: rtl/stream_demux.sv
// Demux top lives in stream_demux_rr.sv; this file holds the shared target/ready helper.
module stream_demux_tgt
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int DW    = $clog2(N_OUT)
) (
  input  logic             rr_mode,
  input  logic [DW-1:0]    rr_ptr,
  input  logic [DW-1:0]    up_dest,
  input  logic [N_OUT-1:0] slot_vld,
  input  logic [N_OUT-1:0] down_ready,
  output logic [DW-1:0]    tgt,
  output logic             tgt_rdy
);

  assign tgt     = rr_mode ? rr_ptr : up_dest;
  // Head-of-line: only the targeted slot decides, other empty slots do not help.
  assign tgt_rdy = !slot_vld[tgt] | down_ready[tgt];

endmodule

// File: rtl/stream_slot.sv
// One-entry output register: valid bit plus payload, loaded on accept, cleared on drain.
// Latency 1; a load in the same cycle as a drain wins, so the slot stays full with new data.
module stream_slot
  import stream_demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] load_data,
  output logic         vld,
  output logic [W-1:0] dat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (load) begin
      vld <= 1'b1;
      dat <= load_data;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_rr.sv
// Demultiplexes one valid/ready stream onto N_OUT one-entry output slots, addressed or round-robin.
// Latency 1 cycle; up_ready follows only the targeted slot (full and not draining blocks upstream).
module stream_demux_rr
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int W     = W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rr_mode,
  input  logic                      up_valid,
  output logic                      up_ready,
  input  logic [W-1:0]              up_data,
  input  logic [$clog2(N_OUT)-1:0]  up_dest,
  output logic [N_OUT-1:0]          down_valid,
  input  logic [N_OUT-1:0]          down_ready,
  output logic [N_OUT-1:0][W-1:0]   down_data,
  output logic [$clog2(N_OUT)-1:0]  rr_ptr
);

  localparam int DW = $clog2(N_OUT);

  logic [DW-1:0]    tgt;
  logic             accept_vld;
  logic [N_OUT-1:0] load_vld;
  logic [N_OUT-1:0] drain_vld;

  stream_demux_tgt #(.N_OUT(N_OUT), .DW(DW)) u_tgt (
    .rr_mode    (rr_mode),
    .rr_ptr     (rr_ptr),
    .up_dest    (up_dest),
    .slot_vld   (down_valid),
    .down_ready (down_ready),
    .tgt        (tgt),
    .tgt_rdy    (up_ready)
  );

  assign accept_vld = up_valid & up_ready;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign load_vld[i]  = accept_vld & (tgt == DW'(i));
    assign drain_vld[i] = down_valid[i] & down_ready[i];

    stream_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_vld[i]),
      .drain     (drain_vld[i]),
      .load_data (up_data),
      .vld       (down_valid[i]),
      .dat       (down_data[i])
    );
  end

  // N_OUT is a power of two, so the natural DW-bit overflow gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept_vld && rr_mode) begin
      rr_ptr <= rr_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_rr.sv
// Directed and scoreboard checks for stream_demux_rr at N_OUT=4, W=8.
module tb_stream_demux_rr;

  logic            clk;
  logic            rst_n;
  logic            rr_mode;
  logic            up_valid;
  logic            up_ready;
  logic [7:0]      up_data;
  logic [1:0]      up_dest;
  logic [3:0]      down_valid;
  logic [3:0]      down_ready;
  logic [3:0][7:0] down_data;
  logic [1:0]      rr_ptr;

  int n_chk;
  int n_fail;

  logic [7:0] sb_q [4][$];
  logic [1:0] mdl_ptr;

  stream_demux_rr #(.N_OUT(4), .W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rr_mode    (rr_mode),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_dest    (up_dest),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .rr_ptr     (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic [1:0] dst);
    up_valid = 1'b1;
    up_data  = d;
    up_dest  = dst;
  endtask

  localparam logic [7:0] RR_DAT [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  localparam int         RR_CH  [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    rr_mode    = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'hEE;
    up_dest    = 2'd1;
    down_ready = 4'b0000;

    // Reset: empty, pointer zero, ready high, no accept while held.
    #2;
    chk("rst_vld", {28'd0, down_valid}, 32'h0);
    chk("rst_ptr", {30'd0, rr_ptr}, 32'h0);
    chk("rst_rdy", {31'd0, up_ready}, 32'h1);
    tick();
    tick();
    chk("rst_no_accept", {28'd0, down_valid}, 32'h0);
    up_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Addressed mode.
    down_ready = 4'b1111;
    beat(8'hA1, 2'd2);
    tick();
    chk("addr_vld_a1", {28'd0, down_valid}, 32'h4);
    chk("addr_dat_a1", {24'd0, down_data[2]}, 32'hA1);
    beat(8'hB2, 2'd0);
    tick();
    chk("addr_vld_b2", {28'd0, down_valid}, 32'h1);
    chk("addr_dat_b2", {24'd0, down_data[0]}, 32'hB2);
    up_valid = 1'b0;
    tick();
    chk("addr_drained", {28'd0, down_valid}, 32'h0);
    chk("addr_ptr_hold", {30'd0, rr_ptr}, 32'h0);

    // Round-robin with wrap.
    rr_mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      beat(RR_DAT[k], 2'd3);
      tick();
      chk("rr_vld", {28'd0, down_valid}, 32'h1 << RR_CH[k]);
      chk("rr_dat", {24'd0, down_data[RR_CH[k]]}, {24'd0, RR_DAT[k]});
    end
    chk("rr_ptr_end", {30'd0, rr_ptr}, 32'h1);
    up_valid = 1'b0;
    tick();

    // Backpressure and head-of-line blocking on channel 1.
    rr_mode    = 1'b0;
    down_ready = 4'b1101;
    beat(8'h31, 2'd1);
    tick();
    chk("bp_first_vld", {31'd0, down_valid[1]}, 32'h1);
    beat(8'h32, 2'd1);
    #1;
    chk("bp_rdy_low", {31'd0, up_ready}, 32'h0);
    tick();
    chk("bp_stable", {24'd0, down_data[1]}, 32'h31);
    chk("bp_rdy_still_low", {31'd0, up_ready}, 32'h0);
    chk("bp_hol_others_empty", {28'd0, down_valid}, 32'h2);
    down_ready = 4'b1111;
    #1;
    chk("bp_rdy_high", {31'd0, up_ready}, 32'h1);
    tick();
    chk("bp_second_vld", {31'd0, down_valid[1]}, 32'h1);
    chk("bp_second_dat", {24'd0, down_data[1]}, 32'h32);
    up_valid = 1'b0;
    tick();
    chk("bp_drained", {28'd0, down_valid}, 32'h0);

    // Same-cycle drain and load on channel 3.
    down_ready = 4'b0000;
    beat(8'h55, 2'd3);
    tick();
    chk("dl_full", {24'd0, down_data[3]}, 32'h55);
    down_ready = 4'b1000;
    beat(8'h66, 2'd3);
    #1;
    chk("dl_rdy", {31'd0, up_ready}, 32'h1);
    tick();
    chk("dl_vld", {31'd0, down_valid[3]}, 32'h1);
    chk("dl_dat", {24'd0, down_data[3]}, 32'h66);
    up_valid = 1'b0;
    tick();
    chk("dl_drained", {31'd0, down_valid[3]}, 32'h0);

    // Build slots 0,2 full with pointer 3, then reset between edges.
    rr_mode    = 1'b1;
    down_ready = 4'b0010;
    beat(8'h41, 2'd0);
    tick();
    beat(8'h42, 2'd0);
    tick();
    rr_mode = 1'b0;
    beat(8'h40, 2'd0);
    tick();
    up_valid = 1'b0;
    chk("ar_pre_vld", {28'd0, down_valid}, 32'h5);
    chk("ar_pre_ptr", {30'd0, rr_ptr}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld_async", {28'd0, down_valid}, 32'h0);
    chk("ar_ptr_async", {30'd0, rr_ptr}, 32'h0);
    tick();
    rst_n      = 1'b1;
    rr_mode    = 1'b1;
    down_ready = 4'b1111;
    beat(8'h77, 2'd2);
    tick();
    chk("ar_first_vld", {28'd0, down_valid}, 32'h1);
    chk("ar_first_dat", {24'd0, down_data[0]}, 32'h77);
    chk("ar_first_ptr", {30'd0, rr_ptr}, 32'h1);
    up_valid = 1'b0;
    tick();

    // Random scoreboard from a fresh reset.
    rst_n = 1'b0;
    #2;
    rst_n   = 1'b1;
    mdl_ptr = 2'd0;
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [3:0] exp_vld;
      logic [1:0] t;
      logic       exp_rdy;
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      up_valid   = ($urandom_range(0, 3) != 0);
      up_data    = 8'($urandom);
      up_dest    = 2'($urandom);
      down_ready = 4'($urandom);
      #2;
      for (int i = 0; i < 4; i++) exp_vld[i] = (sb_q[i].size() != 0);
      chk("sb_vld", {28'd0, down_valid}, {28'd0, exp_vld});
      t       = rr_mode ? mdl_ptr : up_dest;
      exp_rdy = !exp_vld[t] | down_ready[t];
      chk("sb_rdy", {31'd0, up_ready}, {31'd0, exp_rdy});
      for (int i = 0; i < 4; i++) begin
        if (exp_vld[i] && down_ready[i]) begin
          chk("sb_dat", {24'd0, down_data[i]}, {24'd0, sb_q[i][0]});
          void'(sb_q[i].pop_front());
        end
      end
      if (up_valid && exp_rdy) begin
        sb_q[t].push_back(up_data);
        if (rr_mode) mdl_ptr = mdl_ptr + 2'd1;
      end
      tick();
    end
    up_valid   = 1'b0;
    down_ready = 4'b1111;
    #2;
    for (int i = 0; i < 4; i++) begin
      if (sb_q[i].size() != 0) begin
        chk("sb_tail_dat", {24'd0, down_data[i]}, {24'd0, sb_q[i][0]});
        void'(sb_q[i].pop_front());
      end
    end
    tick();
    chk("sb_final_empty", {28'd0, down_valid}, 32'h0);
    chk("sb_final_ptr", {30'd0, rr_ptr}, {30'd0, mdl_ptr});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
